// File: rtl/membus_if.sv
// Membus signal bundle between an initiator (master) and a memory responder (slave).
interface membus_if;
  logic         membus_rq_cyc;
  logic         membus_rd_rq;
  logic         membus_wr_rq;
  logic [21:35] membus_ma;
  logic [18:21] membus_sel;
  logic         membus_fmc_select;
  logic [0:35]  membus_mb_in;
  logic         membus_wr_rs;
  logic [0:35]  membus_mb_out;
  logic         membus_addr_ack;
  logic         membus_rd_rs;

  modport master (
    output membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_ma, membus_sel,
           membus_fmc_select, membus_mb_in, membus_wr_rs,
    input  membus_mb_out, membus_addr_ack, membus_rd_rs
  );

  modport slave (
    input  membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_ma, membus_sel,
           membus_fmc_select, membus_mb_in, membus_wr_rs,
    output membus_mb_out, membus_addr_ack, membus_rd_rs
  );
endinterface

// File: rtl/membus_sram_mem.sv
// Membus memory responder backed by a synchronous RAM with fixed access timing.
// Supports read, write and read-modify-write cycles; an abort (rq_cyc or power
// falling) returns to idle without writing and suppresses pending pulses.
module membus_sram_mem #(
  parameter logic [3:0]  MODULE_SEL = 4'o0,
  parameter int unsigned ADDR_BITS  = 14,
  parameter int unsigned ACK_DLY    = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     power,
  membus_if.slave  bus
);

  localparam int unsigned DEPTH  = 1 << ADDR_BITS;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 36;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACKW,
    S_RDA,
    S_RDD,
    S_WRW,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [ADDR_BITS-1:0]   r_addr;
  logic                   r_rd;
  logic                   r_wr;
  logic [0:DATA_W-1]      r_mb_out;
  logic                   r_addr_ack;
  logic                   r_rd_rs;
  logic [0:DATA_W-1]      r_rdata;
  logic [0:DATA_W-1]      r_core [0:DEPTH-1];

  logic w_hi_zero;
  logic w_live;
  logic w_accept;
  logic w_wr_en;

  // Address bits above the implemented range must be zero for the word to exist.
  assign w_hi_zero = (bus.membus_ma >> ADDR_BITS) == 15'd0;
  assign w_live    = power & bus.membus_rq_cyc;
  assign w_accept  = w_live & (bus.membus_rd_rq | bus.membus_wr_rq) &
                     ~bus.membus_fmc_select & (bus.membus_sel == MODULE_SEL) &
                     w_hi_zero;
  assign w_wr_en   = (r_state == S_WRW) & w_live & bus.membus_wr_rs;

  // Cycle sequencer: accept, delayed ack, read data return, write wait, completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_mb_out   <= '0;
      r_addr_ack <= 1'b0;
      r_rd_rs    <= 1'b0;
    end else begin
      r_addr_ack <= 1'b0;
      r_rd_rs    <= 1'b0;
      if ((r_state != S_IDLE) && !w_live) begin
        // Abort: drop the cycle, release the bus, no write.
        r_state  <= S_IDLE;
        r_mb_out <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_addr  <= ADDR_BITS'(bus.membus_ma);
              r_rd    <= bus.membus_rd_rq;
              r_wr    <= bus.membus_wr_rq;
              r_cnt   <= CNT_W'(ACK_DLY);
              r_state <= S_ACKW;
            end
          end
          S_ACKW: begin
            if (r_cnt == CNT_W'(1)) begin
              r_cnt      <= '0;
              r_addr_ack <= 1'b1;
              r_state    <= r_rd ? S_RDA : S_WRW;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          S_RDA: begin
            r_state <= S_RDD;
          end
          S_RDD: begin
            r_mb_out <= r_rdata;
            r_rd_rs  <= 1'b1;
            r_state  <= r_wr ? S_WRW : S_DONE;
          end
          S_WRW: begin
            if (bus.membus_wr_rs) begin
              r_mb_out <= '0;
              r_state  <= S_DONE;
            end
          end
          S_DONE: begin
            r_state <= S_DONE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // RAM array and its read register; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_core[r_addr] <= bus.membus_mb_in;
    end
    if (r_state == S_RDA) begin
      r_rdata <= r_core[r_addr];
    end
  end

  assign bus.membus_mb_out   = r_mb_out;
  assign bus.membus_addr_ack = r_addr_ack;
  assign bus.membus_rd_rs    = r_rd_rs;

endmodule

// File: tb/tb_membus_sram_mem.sv
// Bench for membus_sram_mem: a driver issues membus cycles and queues the
// expected pulses/bus values; a negedge monitor checks them against the DUT.
module tb_membus_sram_mem;

  localparam int AB = 14;
  localparam int D  = 2;

  typedef enum int {K_ACK, K_RDRS, K_MBZ} kind_t;
  typedef struct {
    kind_t       kind;
    int          at;
    logic [35:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic power = 1'b1;

  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  logic [35:0] mem [int];
  bit   ack_exp;
  bit   rd_exp;

  membus_if bus();

  membus_sram_mem #(
    .MODULE_SEL (4'o0),
    .ADDR_BITS  (AB),
    .ACK_DLY    (D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .power (power),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every expected event due this cycle is checked; any pulse without one is an error.
  always @(negedge clk) begin
    ack_exp = 1'b0;
    rd_exp  = 1'b0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].at < cyc) begin
        checks++;
        failures++;
        $display("FAIL stale_event kind=%0d due=%0d now=%0d", q[i].kind, q[i].at, cyc);
        q.delete(i);
      end else if (q[i].at == cyc) begin
        checks++;
        case (q[i].kind)
          K_ACK: begin
            ack_exp = 1'b1;
            if (bus.membus_addr_ack !== 1'b1) begin
              failures++;
              $display("FAIL addr_ack cyc=%0d actual=%b required=1", cyc, bus.membus_addr_ack);
            end
          end
          K_RDRS: begin
            rd_exp = 1'b1;
            if (bus.membus_rd_rs !== 1'b1 || bus.membus_mb_out !== q[i].data) begin
              failures++;
              $display("FAIL rd_rs_data cyc=%0d actual rd_rs=%b mb_out=%o required rd_rs=1 mb_out=%o",
                       cyc, bus.membus_rd_rs, bus.membus_mb_out, q[i].data);
            end
          end
          default: begin
            if (bus.membus_mb_out !== 36'o0) begin
              failures++;
              $display("FAIL mb_out_zero cyc=%0d actual=%o required=0", cyc, bus.membus_mb_out);
            end
          end
        endcase
        q.delete(i);
      end
    end
    if (bus.membus_addr_ack !== 1'b0 && !ack_exp) begin
      checks++;
      failures++;
      $display("FAIL unexpected_addr_ack cyc=%0d actual=%b required=0", cyc, bus.membus_addr_ack);
    end
    if (bus.membus_rd_rs !== 1'b0 && !rd_exp) begin
      checks++;
      failures++;
      $display("FAIL unexpected_rd_rs cyc=%0d actual=%b required=0", cyc, bus.membus_rd_rs);
    end
  end

  function automatic int key(input logic [14:0] ma);
    return int'(ma) & ((1 << AB) - 1);
  endfunction

  function automatic logic [35:0] rnd36();
    return {4'($urandom), 32'($urandom)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input kind_t k, input int at, input logic [35:0] d);
    exp_t e;
    e.kind = k;
    e.at   = at;
    e.data = d;
    q.push_back(e);
  endtask

  // Raise a request while idle; a is the cycle number of the accept edge.
  task automatic issue(input bit rd, input bit wr, input logic [14:0] ma, output int a);
    bus.membus_ma         = ma;
    bus.membus_sel        = 4'o0;
    bus.membus_fmc_select = 1'b0;
    bus.membus_rd_rq      = rd;
    bus.membus_wr_rq      = wr;
    bus.membus_rq_cyc     = 1'b1;
    tick();
    a = cyc;
    // Request qualifiers after accept must not matter.
    bus.membus_rd_rq = 1'($urandom);
    bus.membus_wr_rq = 1'($urandom);
    bus.membus_ma    = 15'($urandom);
  endtask

  task automatic drop();
    bus.membus_rq_cyc = 1'b0;
    bus.membus_rd_rq  = 1'b0;
    bus.membus_wr_rq  = 1'b0;
    tick();
    push(K_MBZ, cyc, '0);
  endtask

  task automatic do_read(input logic [14:0] ma, input int hold);
    int a;
    issue(1'b1, 1'b0, ma, a);
    push(K_ACK, a + D, '0);
    push(K_RDRS, a + D + 2, mem[key(ma)]);
    while (cyc < a + D + 2) tick();
    for (int i = 0; i < hold; i++) begin
      // A stray write restart outside the write wait must be ignored.
      bus.membus_mb_in = rnd36();
      bus.membus_wr_rs = (i == 0);
      tick();
    end
    bus.membus_wr_rs = 1'b0;
    drop();
  endtask

  task automatic do_write(input logic [14:0] ma, input logic [35:0] data, input int wt);
    int a;
    issue(1'b0, 1'b1, ma, a);
    push(K_ACK, a + D, '0);
    while (cyc < a + D + wt) tick();
    bus.membus_mb_in = data;
    bus.membus_wr_rs = 1'b1;
    tick();
    bus.membus_wr_rs = 1'b0;
    bus.membus_mb_in = rnd36();
    push(K_MBZ, cyc, '0);
    mem[key(ma)] = data;
    drop();
  endtask

  task automatic do_rmw(input logic [14:0] ma, input logic [35:0] data, input int wt);
    int a;
    issue(1'b1, 1'b1, ma, a);
    push(K_ACK, a + D, '0);
    push(K_RDRS, a + D + 2, mem[key(ma)]);
    while (cyc < a + D + 2 + wt) tick();
    bus.membus_mb_in = data;
    bus.membus_wr_rs = 1'b1;
    tick();
    bus.membus_wr_rs = 1'b0;
    push(K_MBZ, cyc, '0);
    mem[key(ma)] = data;
    drop();
  endtask

  // Hold a request that must be refused for 20 cycles; bus must stay quiet.
  task automatic reject(input int which);
    bus.membus_ma         = 15'o00042;
    bus.membus_sel        = 4'o0;
    bus.membus_fmc_select = 1'b0;
    case (which)
      0: bus.membus_fmc_select = 1'b1;
      1: bus.membus_sel        = 4'o1;
      2: bus.membus_ma         = 15'o40042;
      default: power           = 1'b0;
    endcase
    bus.membus_rd_rq  = 1'b1;
    bus.membus_wr_rq  = 1'b1;
    bus.membus_rq_cyc = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      push(K_MBZ, cyc, '0);
    end
    bus.membus_rq_cyc     = 1'b0;
    bus.membus_rd_rq      = 1'b0;
    bus.membus_wr_rq      = 1'b0;
    bus.membus_fmc_select = 1'b0;
    bus.membus_sel        = 4'o0;
    power                 = 1'b1;
    tick();
  endtask

  logic [14:0] pool [8];

  initial begin
    int a;
    bus.membus_rq_cyc     = 1'b0;
    bus.membus_rd_rq      = 1'b0;
    bus.membus_wr_rq      = 1'b0;
    bus.membus_ma         = '0;
    bus.membus_sel        = 4'o0;
    bus.membus_fmc_select = 1'b0;
    bus.membus_mb_in      = '0;
    bus.membus_wr_rs      = 1'b0;

    // Reset state.
    repeat (3) tick();
    push(K_MBZ, cyc, '0);
    reset = 1'b1;
    tick();

    // Reset in the middle of a read: outputs clear at once, contents retained.
    do_write(15'o1, 36'o1, 1);
    issue(1'b1, 1'b0, 15'o1, a);
    push(K_ACK, a + D, '0);
    while (cyc < a + D + 1) tick();
    reset = 1'b0;
    #1;
    push(K_MBZ, cyc, '0);
    bus.membus_rq_cyc = 1'b0;
    bus.membus_rd_rq  = 1'b0;
    bus.membus_wr_rq  = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    do_read(15'o1, 0);

    // Plain read with data held until rq_cyc drops.
    do_write(15'o1736, 36'o254200000001, 0);
    do_read(15'o1736, 3);

    // Write only, then read back.
    do_write(15'o42, 36'o334000000000, 4);
    do_read(15'o42, 1);

    // Read-modify-write.
    do_write(15'o100, 36'o5, 0);
    do_rmw(15'o100, 36'o6, 2);
    do_read(15'o100, 0);

    // Requests this module must not answer.
    for (int w = 0; w < 4; w++) reject(w);
    do_read(15'o42, 0);

    // Abort in the write wait, then a late write restart: no write happens.
    issue(1'b0, 1'b1, 15'o100, a);
    push(K_ACK, a + D, '0);
    while (cyc < a + D + 1) tick();
    bus.membus_rq_cyc = 1'b0;
    bus.membus_rd_rq  = 1'b0;
    bus.membus_wr_rq  = 1'b0;
    tick();
    push(K_MBZ, cyc, '0);
    bus.membus_mb_in = 36'o7;
    bus.membus_wr_rs = 1'b1;
    tick();
    bus.membus_wr_rs = 1'b0;
    do_read(15'o100, 0);

    // Abort by power loss in the middle of a read-modify-write.
    issue(1'b1, 1'b1, 15'o42, a);
    push(K_ACK, a + D, '0);
    while (cyc < a + D) tick();
    power = 1'b0;
    tick();
    push(K_MBZ, cyc, '0);
    bus.membus_rq_cyc = 1'b0;
    power = 1'b1;
    tick();
    do_read(15'o42, 0);

    // Randomized cycles over a small address pool.
    for (int i = 0; i < 8; i++) begin
      pool[i] = 15'(key(15'($urandom)));
      do_write(pool[i], rnd36(), $urandom_range(0, 2));
    end
    for (int i = 0; i < 40; i++) begin
      int op;
      int p;
      op = $urandom_range(0, 2);
      p  = $urandom_range(0, 7);
      case (op)
        0: do_read(pool[p], $urandom_range(0, 3));
        1: do_write(pool[p], rnd36(), $urandom_range(0, 3));
        default: do_rmw(pool[p], rnd36(), $urandom_range(0, 3));
      endcase
    end

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
